// File: rtl/mem_arbiter.sv
// Two-master (fetch / load-store) round-robin arbiter in front of a single memory port.
// One transaction in flight; a watchdog turns a hung slave into an error response.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ifu_req_valid,
  output logic                    ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   ifu_addr,
  output logic                    ifu_resp_valid,
  output logic [DATA_WIDTH-1:0]   ifu_rdata,
  output logic                    ifu_resp_err,
  input  logic                    lsu_req_valid,
  output logic                    lsu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr,
  input  logic                    lsu_wen,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata,
  input  logic [DATA_WIDTH/8-1:0] lsu_wmask,
  output logic                    lsu_resp_valid,
  output logic [DATA_WIDTH-1:0]   lsu_rdata,
  output logic                    lsu_resp_err,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_wen,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  typedef enum logic {M_IFU, M_LSU} master_t;

  state_t                state;
  master_t               owner;
  master_t               last_grant;
  logic [CW-1:0]         cnt;
  logic                  grant_ifu;
  logic                  grant_lsu;
  logic                  busy;
  logic                  done;
  logic                  expired;
  logic                  resp_err;
  logic [DATA_WIDTH-1:0] resp_data;

  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state == S_IDLE) begin
      grant_ifu = ifu_req_valid && (!lsu_req_valid || last_grant == M_LSU);
      grant_lsu = lsu_req_valid && (!ifu_req_valid || last_grant == M_IFU);
    end
    busy      = (state == S_REQ) || (state == S_WAIT);
    done      = (state == S_WAIT) && mem_resp_valid;
    // A completion in the same cycle as expiry wins and is reported without error.
    expired   = busy && !done && (cnt == CW'(TIMEOUT - 1));
    resp_err  = !done;
    resp_data = (done && !mem_wen) ? mem_rdata : '0;
  end

  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      owner          <= M_IFU;
      last_grant     <= M_LSU;
      cnt            <= '0;
      mem_req_valid  <= 1'b0;
      mem_addr       <= '0;
      mem_wen        <= 1'b0;
      mem_wdata      <= '0;
      mem_wmask      <= '0;
      ifu_resp_valid <= 1'b0;
      ifu_rdata      <= '0;
      ifu_resp_err   <= 1'b0;
      lsu_resp_valid <= 1'b0;
      lsu_rdata      <= '0;
      lsu_resp_err   <= 1'b0;
    end else begin
      ifu_resp_valid <= 1'b0;
      lsu_resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_ifu) begin
            mem_addr      <= ifu_addr;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            owner         <= M_IFU;
            last_grant    <= M_IFU;
            cnt           <= '0;
            mem_req_valid <= 1'b1;
            state         <= S_REQ;
          end else if (grant_lsu) begin
            mem_addr      <= lsu_addr;
            mem_wen       <= lsu_wen;
            mem_wdata     <= lsu_wdata;
            mem_wmask     <= lsu_wmask;
            owner         <= M_LSU;
            last_grant    <= M_LSU;
            cnt           <= '0;
            mem_req_valid <= 1'b1;
            state         <= S_REQ;
          end
        end
        S_REQ, S_WAIT: begin
          cnt <= cnt + CW'(1);
          if (done || expired) begin
            if (owner == M_IFU) begin
              ifu_resp_valid <= 1'b1;
              ifu_rdata      <= resp_data;
              ifu_resp_err   <= resp_err;
            end else begin
              lsu_resp_valid <= 1'b1;
              lsu_rdata      <= resp_data;
              lsu_resp_err   <= resp_err;
            end
            mem_req_valid <= 1'b0;
            state         <= S_IDLE;
          end else if (state == S_REQ && mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= S_WAIT;
          end
        end
        default: begin
          mem_req_valid <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle vectors for fetch/tie/store/stray-response,
// hand sequences for watchdog expiry, expiry-vs-completion boundary and async reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask, mem_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_pass  = 0;
  int n_total = 0;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct packed {
    logic        rb, iv;
    logic [31:0] ia;
    logic        lv;
    logic [31:0] la;
    logic        lw;
    logic [31:0] ld;
    logic [3:0]  lm;
    logic        mrdy, mrv;
    logic [31:0] mrd;
    logic        irdy, lrdy, mv;
    logic [31:0] ma;
    logic        mw;
    logic [31:0] md;
    logic [3:0]  mm;
    logic        irv, ie;
    logic [31:0] ird;
    logic        lrv, le;
    logic [31:0] lrd;
  } vec_t;

  vec_t tbl[$];
  vec_t v;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic clear_inputs();
    ifu_req_valid = 1'b0; ifu_addr = '0;
    lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
  endtask

  task automatic next();
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    clear_inputs();
    // Single IFU fetch from reset
    v = '{rb:1, iv:1, ia:32'h80000000, irdy:1, default:'0}; tbl.push_back(v);
    v = '{mrdy:1, mv:1, ma:32'h80000000, default:'0}; tbl.push_back(v);
    v = '{ma:32'h80000000, default:'0}; tbl.push_back(v);
    v = '{mrv:1, mrd:32'h00100073, ma:32'h80000000, default:'0}; tbl.push_back(v);
    v = '{ma:32'h80000000, irv:1, ird:32'h00100073, default:'0}; tbl.push_back(v);
    v = '{ma:32'h80000000, ird:32'h00100073, default:'0}; tbl.push_back(v);
    // Ties after reset: IFU, then LSU (granted during IFU pulse), then IFU again
    v = '{rb:1, iv:1, ia:32'h80000004, lv:1, la:32'h80002000, irdy:1, default:'0}; tbl.push_back(v);
    v = '{lv:1, la:32'h80002000, mrdy:1, mv:1, ma:32'h80000004, default:'0}; tbl.push_back(v);
    v = '{lv:1, la:32'h80002000, mrv:1, mrd:32'h11111111, ma:32'h80000004, default:'0}; tbl.push_back(v);
    v = '{iv:1, ia:32'h80000008, lv:1, la:32'h80002000, lrdy:1, ma:32'h80000004, irv:1, ird:32'h11111111, default:'0}; tbl.push_back(v);
    v = '{iv:1, ia:32'h80000008, mrdy:1, mv:1, ma:32'h80002000, ird:32'h11111111, default:'0}; tbl.push_back(v);
    v = '{iv:1, ia:32'h80000008, mrv:1, mrd:32'h22222222, ma:32'h80002000, ird:32'h11111111, default:'0}; tbl.push_back(v);
    v = '{iv:1, ia:32'h80000008, lv:1, la:32'h80002004, irdy:1, ma:32'h80002000, ird:32'h11111111, lrv:1, lrd:32'h22222222, default:'0}; tbl.push_back(v);
    v = '{lv:1, la:32'h80002004, mrdy:1, mv:1, ma:32'h80000008, ird:32'h11111111, lrd:32'h22222222, default:'0}; tbl.push_back(v);
    v = '{lv:1, la:32'h80002004, mrv:1, mrd:32'h33333333, ma:32'h80000008, ird:32'h11111111, lrd:32'h22222222, default:'0}; tbl.push_back(v);
    v = '{lv:1, la:32'h80002004, lrdy:1, ma:32'h80000008, irv:1, ird:32'h33333333, lrd:32'h22222222, default:'0}; tbl.push_back(v);
    v = '{mrdy:1, mv:1, ma:32'h80002004, ird:32'h33333333, lrd:32'h22222222, default:'0}; tbl.push_back(v);
    v = '{mrv:1, mrd:32'h44444444, ma:32'h80002004, ird:32'h33333333, lrd:32'h22222222, default:'0}; tbl.push_back(v);
    v = '{ma:32'h80002004, ird:32'h33333333, lrv:1, lrd:32'h44444444, default:'0}; tbl.push_back(v);
    // LSU store with slave holding off mem_req_ready for 3 cycles
    v = '{lv:1, la:32'h80001000, lw:1, ld:32'hDEADBEEF, lm:4'hF, lrdy:1, ma:32'h80002004, ird:32'h33333333, lrd:32'h44444444, default:'0}; tbl.push_back(v);
    for (int i = 0; i < 3; i++) begin
      v = '{mv:1, ma:32'h80001000, mw:1, md:32'hDEADBEEF, mm:4'hF, ird:32'h33333333, lrd:32'h44444444, default:'0}; tbl.push_back(v);
    end
    v = '{mrdy:1, mv:1, ma:32'h80001000, mw:1, md:32'hDEADBEEF, mm:4'hF, ird:32'h33333333, lrd:32'h44444444, default:'0}; tbl.push_back(v);
    v = '{mrv:1, mrd:32'hCAFEF00D, ma:32'h80001000, mw:1, md:32'hDEADBEEF, mm:4'hF, ird:32'h33333333, lrd:32'h44444444, default:'0}; tbl.push_back(v);
    v = '{ma:32'h80001000, mw:1, md:32'hDEADBEEF, mm:4'hF, ird:32'h33333333, lrv:1, lrd:32'h0, default:'0}; tbl.push_back(v);
    v = '{ma:32'h80001000, mw:1, md:32'hDEADBEEF, mm:4'hF, ird:32'h33333333, default:'0}; tbl.push_back(v);
    // Slave response in IDLE and in REQ must be ignored
    v = '{mrv:1, mrd:32'h55555555, ma:32'h80001000, mw:1, md:32'hDEADBEEF, mm:4'hF, ird:32'h33333333, default:'0}; tbl.push_back(v);
    v = '{iv:1, ia:32'h80000010, irdy:1, ma:32'h80001000, mw:1, md:32'hDEADBEEF, mm:4'hF, ird:32'h33333333, default:'0}; tbl.push_back(v);
    v = '{mrv:1, mrd:32'h66666666, mv:1, ma:32'h80000010, ird:32'h33333333, default:'0}; tbl.push_back(v);
    v = '{mrdy:1, mv:1, ma:32'h80000010, ird:32'h33333333, default:'0}; tbl.push_back(v);
    v = '{mrv:1, mrd:32'h77777777, ma:32'h80000010, ird:32'h33333333, default:'0}; tbl.push_back(v);
    v = '{ma:32'h80000010, irv:1, ird:32'h77777777, default:'0}; tbl.push_back(v);

    foreach (tbl[i]) begin
      if (tbl[i].rb) do_reset();
      next();
      ifu_req_valid = tbl[i].iv;  ifu_addr = tbl[i].ia;
      lsu_req_valid = tbl[i].lv;  lsu_addr = tbl[i].la;  lsu_wen = tbl[i].lw;
      lsu_wdata = tbl[i].ld;      lsu_wmask = tbl[i].lm;
      mem_req_ready = tbl[i].mrdy; mem_resp_valid = tbl[i].mrv; mem_rdata = tbl[i].mrd;
      #1;
      chk($sformatf("v%0d ifu_req_ready", i), ifu_req_ready, tbl[i].irdy);
      chk($sformatf("v%0d lsu_req_ready", i), lsu_req_ready, tbl[i].lrdy);
      chk($sformatf("v%0d mem_req_valid", i), mem_req_valid, tbl[i].mv);
      chk($sformatf("v%0d mem_addr", i), mem_addr, tbl[i].ma);
      chk($sformatf("v%0d mem_wen", i), mem_wen, tbl[i].mw);
      chk($sformatf("v%0d mem_wdata", i), mem_wdata, tbl[i].md);
      chk($sformatf("v%0d mem_wmask", i), mem_wmask, tbl[i].mm);
      chk($sformatf("v%0d ifu_resp_valid", i), ifu_resp_valid, tbl[i].irv);
      chk($sformatf("v%0d ifu_resp_err", i), ifu_resp_err, tbl[i].ie);
      chk($sformatf("v%0d ifu_rdata", i), ifu_rdata, tbl[i].ird);
      chk($sformatf("v%0d lsu_resp_valid", i), lsu_resp_valid, tbl[i].lrv);
      chk($sformatf("v%0d lsu_resp_err", i), lsu_resp_err, tbl[i].le);
      chk($sformatf("v%0d lsu_rdata", i), lsu_rdata, tbl[i].lrd);
    end

    // Watchdog: slave never responds; error pulse 8 edges after the grant edge
    next(); ifu_req_valid = 1'b1; ifu_addr = 32'h80000020; #1;
    chk("to grant ifu_req_ready", ifu_req_ready, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      next(); mem_req_ready = (k == 1); #1;
      chk($sformatf("to c%0d ifu_resp_valid", k), ifu_resp_valid, 1'b0);
      chk($sformatf("to c%0d mem_req_valid", k), mem_req_valid, (k == 1));
    end
    next(); lsu_req_valid = 1'b1; lsu_addr = 32'h80004000; #1;
    chk("to ifu_resp_valid", ifu_resp_valid, 1'b1);
    chk("to ifu_resp_err", ifu_resp_err, 1'b1);
    chk("to ifu_rdata", ifu_rdata, 32'h0);
    chk("to back-in-idle lsu_req_ready", lsu_req_ready, 1'b1);
    next(); mem_req_ready = 1'b1; #1;
    chk("after-to mem_req_valid", mem_req_valid, 1'b1);
    chk("after-to mem_addr", mem_addr, 32'h80004000);
    chk("after-to ifu_resp_valid", ifu_resp_valid, 1'b0);
    next(); mem_resp_valid = 1'b1; mem_rdata = 32'h0000ABCD; #1;
    next(); #1;
    chk("after-to lsu_resp_valid", lsu_resp_valid, 1'b1);
    chk("after-to lsu_resp_err", lsu_resp_err, 1'b0);
    chk("after-to lsu_rdata", lsu_rdata, 32'h0000ABCD);
    chk("after-to ifu_resp_err held", ifu_resp_err, 1'b1);

    // Completion in the expiry cycle resolves as a normal response
    next(); ifu_req_valid = 1'b1; ifu_addr = 32'h80000030; #1;
    chk("edge grant ifu_req_ready", ifu_req_ready, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      next(); mem_req_ready = (k == 1); mem_resp_valid = (k == 8); mem_rdata = 32'h12345678; #1;
      chk($sformatf("edge c%0d ifu_resp_valid", k), ifu_resp_valid, 1'b0);
    end
    next(); #1;
    chk("edge ifu_resp_valid", ifu_resp_valid, 1'b1);
    chk("edge ifu_resp_err", ifu_resp_err, 1'b0);
    chk("edge ifu_rdata", ifu_rdata, 32'h12345678);

    // Async reset during a response pulse clears it without a clock edge
    do_reset();
    next(); ifu_req_valid = 1'b1; ifu_addr = 32'h80000040; #1;
    next(); mem_req_ready = 1'b1; #1;
    next(); mem_resp_valid = 1'b1; mem_rdata = 32'h0BADF00D; #1;
    next(); #1;
    chk("rst-pulse ifu_resp_valid before", ifu_resp_valid, 1'b1);
    #1 rst = 1'b1; #1;
    chk("rst-pulse ifu_resp_valid after", ifu_resp_valid, 1'b0);
    chk("rst-pulse ifu_rdata after", ifu_rdata, 32'h0);
    @(negedge clk); rst = 1'b0;

    // Async reset in REQ drops mem_req_valid immediately
    next(); ifu_req_valid = 1'b1; ifu_addr = 32'h80000050; #1;
    next(); #1;
    chk("rst-req mem_req_valid before", mem_req_valid, 1'b1);
    #1 rst = 1'b1; #1;
    chk("rst-req mem_req_valid after", mem_req_valid, 1'b0);
    chk("rst-req mem_addr after", mem_addr, 32'h0);
    @(negedge clk); rst = 1'b0;

    // Async reset in WAIT: aborted request never answered, next tie goes to IFU
    next(); lsu_req_valid = 1'b1; lsu_addr = 32'h80003000; #1;
    chk("rst-wait lsu_req_ready", lsu_req_ready, 1'b1);
    next(); mem_req_ready = 1'b1; #1;
    next(); #1;
    #1 rst = 1'b1; #1;
    chk("rst-wait mem_req_valid", mem_req_valid, 1'b0);
    chk("rst-wait lsu_resp_valid", lsu_resp_valid, 1'b0);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      next(); mem_resp_valid = (k == 0); mem_rdata = 32'h99999999; #1;
      chk($sformatf("rst-wait c%0d lsu_resp_valid", k), lsu_resp_valid, 1'b0);
      chk($sformatf("rst-wait c%0d ifu_resp_valid", k), ifu_resp_valid, 1'b0);
    end
    next(); ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; #1;
    chk("rst-wait tie ifu_req_ready", ifu_req_ready, 1'b1);
    chk("rst-wait tie lsu_req_ready", lsu_req_ready, 1'b0);
    next(); #1;
    chk("rst-wait lsu_rdata", lsu_rdata, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, one-slave memory arbiter and transaction sequencer for the npc core. It shares a single memory port between the instruction fetch path and the load/store path. Requests are granted round-robin and one transaction is outstanding at a time. Each response is routed back to the master that issued the request, and a hung slave is converted into an error response by a watchdog counter. It sits between the core's fetch/load-store logic and the DPI-backed or SoC memory.

## Interface
- ADDR_WIDTH, 32, address width of all address ports
- DATA_WIDTH, 32, data width; wmask width is DATA_WIDTH/8
- TIMEOUT, 255, cycles spent in REQ+WAIT before an error response; must be ≥ 2
- clk  in  1  clock; all state changes on posedge
- rst  in  1  reset is asynchronous and active-high
- ifu_req_valid  in  1  fetch request
- ifu_req_ready  out  1  fetch request accepted this cycle
- ifu_addr  in  ADDR_WIDTH  fetch address (read only)
- ifu_resp_valid  out  1  one-cycle fetch response pulse
- ifu_rdata  out  DATA_WIDTH  fetch data
- ifu_resp_err  out  1  fetch timed out
- lsu_req_valid  in  1  load/store request
- lsu_req_ready  out  1  load/store request accepted this cycle
- lsu_addr  in  ADDR_WIDTH  data address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  DATA_WIDTH  store data
- lsu_wmask  in  DATA_WIDTH/8  byte enables for stores
- lsu_resp_valid  out  1  one-cycle load/store response pulse
- lsu_rdata  out  DATA_WIDTH  load data; 0 for stores
- lsu_resp_err  out  1  load/store timed out
- mem_req_valid  out  1  request to slave
- mem_req_ready  in  1  slave accepts request
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  as above  latched request fields
- mem_resp_valid  in  1  slave response
- mem_rdata  in  DATA_WIDTH  slave read data

## Operation
- FSM states: IDLE, REQ, WAIT. Registers:
  - owner (IFU/LSU)
  - last_grant (IFU/LSU)
  - latched addr/wen/wdata/wmask
  - timeout counter, width ceil(log2(TIMEOUT+1))
  - response output registers
- IDLE:
  - Grant rule:
    - If exactly one req_valid is high, grant it.
    - If both are high, grant the master that is not last_grant.
  - The granted master's req_ready is combinationally 1 only in IDLE while its valid is high. The other master's ready stays 0.
  - On the grant edge:
    - Latch the request fields. IFU forces wen=0, wdata=0, wmask=0.
    - Set owner = last_grant = granted master.
    - Clear the counter.
    - Go to REQ.
- REQ:
  - mem_req_valid=1 with the latched fields, held stable until mem_req_ready.
  - On mem_req_ready, go to WAIT.
- WAIT:
  - mem_resp_valid is sampled only here.
  - On mem_resp_valid, register mem_rdata into the owner's rdata (0 if the transaction was a store). Pulse the owner's resp_valid for exactly one cycle with err=0, and go to IDLE.
- Watchdog:
  - The counter increments every cycle in REQ or WAIT.
  - If it reaches TIMEOUT-1 in a cycle without completion, the owner receives resp_valid=1, err=1, rdata=0, and the FSM returns to IDLE. mem_req_valid drops.
  - After a timeout the slave must not respond to that transaction. mem_resp_valid is ignored in IDLE and REQ.
- Non-owner resp_valid is always 0. rdata/err outputs hold their last value between pulses.
- Masters must hold req fields stable while valid && !ready. Masters accept responses unconditionally (no resp_ready).

## Timing
- Reset values:
  - state=IDLE, last_grant=LSU, so IFU wins the first tie.
  - owner=IFU, counter=0.
  - All *_resp_valid=0, *_resp_err=0, *_rdata=0.
  - mem_req_valid=0, mem_addr/wdata/wmask=0, mem_wen=0.
- Best-case latency:
  - Request accepted at edge 0.
  - mem_req_valid high in cycle 1. If mem_req_ready is high in cycle 1, the FSM is in WAIT in cycle 2.
  - mem_resp_valid in cycle N (N ≥ 2) gives master resp_valid in cycle N+1.
  - The FSM is in IDLE in cycle N+1, so the next grant can happen in cycle N+1.
  - Minimum 3 cycles from acceptance to response.
- Back-to-back: a request presented in the same cycle as its own response pulse may be granted.
- Timeout boundary: completion and timeout in the same cycle resolve as a normal response (err=0).
- rst asserted mid-transaction:
  - The FSM immediately returns to IDLE and mem_req_valid drops asynchronously.
  - No response is issued to the owner.
  - last_grant reverts to LSU.

## Test plan
- Single IFU fetch: ifu_req_valid, addr=0x80000000; slave ready in REQ, responds 2 cycles later with 0x00100073 -> ifu_req_ready pulse, mem_addr=0x80000000, mem_wen=0, ifu_resp_valid one cycle with rdata=0x00100073, lsu_resp_valid never high.
- Tie after reset: both valid in the same cycle -> IFU granted first, LSU granted in the cycle IFU's response pulses; third simultaneous request goes to IFU (alternation).
- LSU store: addr=0x80001000, wdata=0xDEADBEEF, wmask=0xF, slave delays mem_req_ready 3 cycles -> mem fields stable throughout REQ, lsu_resp_valid with rdata=0, err=0.
- Timeout: TIMEOUT=8, slave never asserts mem_resp_valid -> owner gets resp_valid with err=1 and rdata=0 exactly 8 cycles after the grant edge, FSM returns to IDLE, a later grant proceeds normally.
- Async reset in WAIT: assert rst between clock edges -> mem_req_valid and all resp_valid go to 0 without a clock edge, no response is ever issued for the aborted request, first post-reset tie goes to IFU.
- Slave response outside WAIT: mem_resp_valid pulsed in IDLE and in REQ -> ignored, no resp_valid on either master.
